// File: rtl/mac_share_arbiter_if.sv
// Request/grant bundle between the MAC datapath arbiter (slave) and its requesters (master).
// "rel" carries the per-requester end-of-transaction strobe ("release" is a reserved word).
interface mac_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] rel;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [IDW-1:0]     grant_id;
  logic               grant_start;
  logic               timeout_err;

  modport slave (
    input  req, rel,
    output grant, grant_valid, grant_id, grant_start, timeout_err
  );

  modport master (
    output req, rel,
    input  grant, grant_valid, grant_id, grant_start, timeout_err
  );
endinterface

// File: rtl/mac_share_arbiter.sv
// Round-robin, transaction-locking arbiter for the shared MAC datapath, with a one-cycle drain gap.
// Define MAC_ARB_TIMEOUT_EN to enable the watchdog that revokes a grant held for TIMEOUT cycles.
module mac_share_arbiter #(
  parameter int unsigned NUM_REQ = 5,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                reset,
  mac_share_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN  = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT < 2) begin : g_bad_param
    $error("mac_share_arbiter: NUM_REQ must be 2..16 and TIMEOUT >= 2");
  end

  state_t             r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [IDW-1:0]     r_grant_id, w_grant_id_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_start, w_start_nxt;
  logic               r_terr, w_terr_nxt;
  logic [IDW-1:0]     r_last, w_last_nxt;

  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic               w_end;
  logic               w_expire;

  // Rotating search: first requester after the last winner, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      int unsigned idx;
      idx = (32'(r_last) + k) % NUM_REQ;
      if (!w_found && bus.req[idx]) begin
        w_found = 1'b1;
        w_win   = IDW'(idx);
      end
    end
  end

  // Only the owner's release/request bits can end a transaction.
  assign w_end = bus.rel[r_grant_id] | ~bus.req[r_grant_id];

`ifdef MAC_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT);

  logic [CW-1:0] r_cnt, w_cnt_nxt;

  assign w_expire = (r_state == S_OWN) && (r_cnt == CW'(TIMEOUT - 1));

  // Hold counter stops at TIMEOUT-1, where the grant is revoked, so it never wraps.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (r_state == S_IDLE && w_found) begin
      w_cnt_nxt = '0;
    end else if (r_state == S_OWN && !w_end && !w_expire) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end
`else
  assign w_expire = 1'b0;
`endif

  // Next-state and next-output logic; every output leaves through a register.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_valid_nxt    = r_valid;
    w_start_nxt    = 1'b0;
    w_terr_nxt     = 1'b0;
    w_last_nxt     = r_last;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt    = S_OWN;
          w_grant_nxt    = NUM_REQ'(1) << w_win;
          w_grant_id_nxt = w_win;
          w_valid_nxt    = 1'b1;
          w_start_nxt    = 1'b1;
          w_last_nxt     = w_win;
        end
      end
      S_OWN: begin
        if (w_end || w_expire) begin
          w_state_nxt    = S_GAP;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          w_valid_nxt    = 1'b0;
          w_terr_nxt     = w_expire & ~w_end;
        end
      end
      S_GAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
        w_valid_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_valid    <= 1'b0;
      r_start    <= 1'b0;
      r_terr     <= 1'b0;
      r_last     <= IDW'(NUM_REQ - 1);
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_valid    <= w_valid_nxt;
      r_start    <= w_start_nxt;
      r_terr     <= w_terr_nxt;
      r_last     <= w_last_nxt;
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_valid;
  assign bus.grant_id    = r_grant_id;
  assign bus.grant_start = r_start;
  assign bus.timeout_err = r_terr;

endmodule
